// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: req/ack handshake to a variable-latency memory,
// pipeline stall generation, one-entry load buffer for zero-stall repeated loads, timeout abort.
module mem_access_ctrl #(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF,
    parameter bit          HIT_EN   = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] Addr_i,
    input  logic [31:0] WriteData_i,
    output logic [31:0] MemData_o,
    output logic        Stall_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t      r_state;
    logic        r_buf_vld;
    logic [29:0] r_buf_addr;
    logic [31:0] r_buf_data;
    logic [31:0] r_mem_data;
    logic        r_err;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [CW-1:0] r_cnt;

    logic w_access;
    logic w_misal;
    logic w_hit;
    logic w_idle;
    logic w_start;
    logic w_timeout;

    assign w_idle    = (r_state == S_IDLE);
    assign w_access  = MemRead_i | MemWrite_i;
    assign w_misal   = w_access && (Addr_i[1:0] != 2'b00);
    // A buffer hit needs a pure read; a store with MemRead_i also high is still a store.
    assign w_hit     = HIT_EN && r_buf_vld && (r_buf_addr == Addr_i[31:2]) &&
                       MemRead_i && !MemWrite_i && (Addr_i[1:0] == 2'b00);
    assign w_start   = w_idle && w_access && !w_misal && !w_hit;
    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

    assign Stall_o     = w_start || (r_state == S_REQ);
    assign err_o       = r_err;
    assign mem_req_o   = r_req;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;

    always_comb begin
        MemData_o = r_mem_data;
        if (w_idle) begin
            if (w_hit)
                MemData_o = r_buf_data;
            else if (w_misal)
                MemData_o = 32'h0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_buf_vld  <= 1'b0;
            r_buf_addr <= '0;
            r_buf_data <= '0;
            r_mem_data <= '0;
            r_err      <= 1'b0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_misal) begin
                        r_err <= 1'b1;
                    end else if (w_start) begin
                        r_req   <= 1'b1;
                        r_we    <= MemWrite_i;
                        r_addr  <= {Addr_i[31:2], 2'b00};
                        r_wdata <= WriteData_i;
                        r_cnt   <= '0;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_ack_i) begin
                        r_req   <= 1'b0;
                        r_state <= S_DONE;
                        if (!r_we) begin
                            r_mem_data <= mem_rdata_i;
                            r_buf_vld  <= 1'b1;
                            r_buf_addr <= r_addr[31:2];
                            r_buf_data <= mem_rdata_i;
                        end else if (r_buf_vld && (r_buf_addr == r_addr[31:2])) begin
                            r_buf_data <= r_wdata;
                        end
                    end else if (w_timeout) begin
                        // Aborted access: buffer left untouched so it never holds bogus data.
                        r_req   <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                        if (!r_we)
                            r_mem_data <= ERR_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: per-cycle vector table for miss/hit/store/dual-strobe flow,
// plus hand sequences for timeout abort, reset mid-request and misaligned access.
module tb_mem_access_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i, MemWrite_i;
    logic [31:0] Addr_i, WriteData_i;
    logic [31:0] MemData_o;
    logic        Stall_o, err_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    int total = 0;
    int bad   = 0;

    mem_access_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .Addr_i(Addr_i), .WriteData_i(WriteData_i),
        .MemData_o(MemData_o), .Stall_o(Stall_o), .err_o(err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rd, wr;
        logic [31:0] addr, wdata;
        logic        ack;
        logic [31:0] rdata;
        logic        stall, req, we;
        logic [31:0] maddr, data;
        logic        err;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(logic rd, logic wr, logic [31:0] addr, logic [31:0] wdata,
                                logic ack, logic [31:0] rdata, logic stall, logic req,
                                logic we, logic [31:0] maddr, logic [31:0] data, logic err);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.ack = ack; v.rdata = rdata;
        v.stall = stall; v.req = req; v.we = we; v.maddr = maddr; v.data = data; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic ack, input logic [31:0] rdata);
        MemRead_i = rd; MemWrite_i = wr; Addr_i = addr; WriteData_i = wdata;
        mem_ack_i = ack; mem_rdata_i = rdata;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int nreq;

        rst_i = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

        // Load miss with ack in 3rd REQ cycle, repeat-load hit, store write-through, dual strobe.
        vecs[0]  = mk(1,0,32'h40,32'h0,       0,32'h0,       1,0,0,32'h0, 32'h0,       0);
        vecs[1]  = mk(1,0,32'h40,32'h0,       0,32'h0,       1,1,0,32'h40,32'h0,       0);
        vecs[2]  = mk(1,0,32'h40,32'h0,       0,32'h0,       1,1,0,32'h40,32'h0,       0);
        vecs[3]  = mk(1,0,32'h40,32'h0,       1,32'h12345678,1,1,0,32'h40,32'h0,       0);
        vecs[4]  = mk(1,0,32'h40,32'h0,       0,32'h0,       0,0,0,32'h0, 32'h12345678,0);
        vecs[5]  = mk(1,0,32'h40,32'h0,       0,32'h0,       0,0,0,32'h0, 32'h12345678,0);
        vecs[6]  = mk(0,0,32'h0, 32'h0,       0,32'h0,       0,0,0,32'h0, 32'h12345678,0);
        vecs[7]  = mk(0,1,32'h40,32'hCAFEF00D,0,32'h0,       1,0,0,32'h0, 32'h12345678,0);
        vecs[8]  = mk(0,1,32'h40,32'hCAFEF00D,1,32'h0,       1,1,1,32'h40,32'h12345678,0);
        vecs[9]  = mk(0,0,32'h0, 32'h0,       0,32'h0,       0,0,0,32'h0, 32'h12345678,0);
        vecs[10] = mk(1,0,32'h40,32'h0,       0,32'h0,       0,0,0,32'h0, 32'hCAFEF00D,0);
        vecs[11] = mk(1,1,32'h44,32'h11111111,0,32'h0,       1,0,0,32'h0, 32'h12345678,0);
        vecs[12] = mk(1,1,32'h44,32'h11111111,1,32'h99999999,1,1,1,32'h44,32'h12345678,0);
        vecs[13] = mk(0,0,32'h0, 32'h0,       0,32'h0,       0,0,0,32'h0, 32'h12345678,0);

        // Reset state
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        chk("rst_req",   {31'h0, mem_req_o}, 32'h0);
        chk("rst_stall", {31'h0, Stall_o},   32'h0);
        chk("rst_err",   {31'h0, err_o},     32'h0);
        chk("rst_we",    {31'h0, mem_we_o},  32'h0);
        chk("rst_addr",  mem_addr_o,         32'h0);
        chk("rst_wdata", mem_wdata_o,        32'h0);
        chk("rst_data",  MemData_o,          32'h0);
        next_cycle();
        rst_i = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].ack, vecs[i].rdata);
            @(negedge clk_i);
            chk($sformatf("v%0d_stall", i), {31'h0, Stall_o},   {31'h0, vecs[i].stall});
            chk($sformatf("v%0d_req", i),   {31'h0, mem_req_o}, {31'h0, vecs[i].req});
            chk($sformatf("v%0d_data", i),  MemData_o,          vecs[i].data);
            chk($sformatf("v%0d_err", i),   {31'h0, err_o},     {31'h0, vecs[i].err});
            if (vecs[i].req) begin
                chk($sformatf("v%0d_we", i),   {31'h0, mem_we_o}, {31'h0, vecs[i].we});
                chk($sformatf("v%0d_addr", i), mem_addr_o,        vecs[i].maddr);
                if (vecs[i].we)
                    chk($sformatf("v%0d_wdata", i), mem_wdata_o, vecs[i].wdata);
            end
            next_cycle();
        end

        // Timeout: load 0x80, never acked.
        drive(1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 32'h0);
        @(negedge clk_i);
        chk("to_start_stall", {31'h0, Stall_o}, 32'h1);
        chk("to_start_err",   {31'h0, err_o},   32'h0);
        nreq = 0;
        for (int i = 0; i < 40; i++) begin
            next_cycle();
            @(negedge clk_i);
            if (!mem_req_o) break;
            nreq++;
        end
        chk("to_req_cycles", nreq, 32'd16);
        chk("to_done_stall", {31'h0, Stall_o}, 32'h0);
        chk("to_done_data",  MemData_o,        32'hDEADBEEF);
        chk("to_done_err",   {31'h0, err_o},   32'h1);
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h55555555);
        @(negedge clk_i);
        chk("stray_ack_req",  {31'h0, mem_req_o}, 32'h0);
        chk("stray_ack_data", MemData_o,          32'hDEADBEEF);
        next_cycle();
        drive(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0);
        @(negedge clk_i);
        chk("post_to_hit_stall", {31'h0, Stall_o}, 32'h0);
        chk("post_to_hit_data",  MemData_o,        32'hCAFEF00D);
        next_cycle();

        // Reset asserted in the 2nd REQ cycle.
        drive(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0);
        next_cycle();
        @(negedge clk_i);
        chk("rr_req1", {31'h0, mem_req_o}, 32'h1);
        next_cycle();
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rr_req2", {31'h0, mem_req_o}, 32'h1);
        next_cycle();
        rst_i = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h77777777);
        @(negedge clk_i);
        chk("rr_after_req",   {31'h0, mem_req_o}, 32'h0);
        chk("rr_after_stall", {31'h0, Stall_o},   32'h0);
        chk("rr_after_err",   {31'h0, err_o},     32'h0);
        next_cycle();
        drive(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0);
        @(negedge clk_i);
        chk("rr_miss_stall", {31'h0, Stall_o}, 32'h1);
        next_cycle();
        drive(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 32'hA5A5A5A5);
        @(negedge clk_i);
        chk("rr_miss_req", {31'h0, mem_req_o}, 32'h1);
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        @(negedge clk_i);
        chk("rr_done_data", MemData_o, 32'hA5A5A5A5);
        next_cycle();

        // Misaligned load.
        drive(1'b1, 1'b0, 32'h43, 32'h0, 1'b0, 32'h0);
        @(negedge clk_i);
        chk("mis_stall", {31'h0, Stall_o},   32'h0);
        chk("mis_req",   {31'h0, mem_req_o}, 32'h0);
        chk("mis_data",  MemData_o,          32'h0);
        chk("mis_err0",  {31'h0, err_o},     32'h0);
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        @(negedge clk_i);
        chk("mis_err1",  {31'h0, err_o},     32'h1);
        chk("mis_req1",  {31'h0, mem_req_o}, 32'h0);
        chk("mis_data1", MemData_o,          32'hA5A5A5A5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
